param_ring_counter: RTL and testbench
=====================================

Name: param_ring_counter

Overview:
- Parametrised successor to the team's fixed 8-bit one-hot counter.
- Generates a WIDTH-bit ring code with run-time direction, mode (one-hot or Johnson), synchronous position load, binary position readout and a wrap pulse.
- Used as a phase/slot sequencer feeding multiplexers and LED/scan drivers.

Parameters:
- WIDTH, 8, number of output bits; legal range 2..32.
- RESET_POS, 0, one-hot bit index set after reset; must be less than WIDTH.
- PW, $clog2(2*WIDTH), width of pos/load_pos; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; 0 = reset.
- enable  input  1  advance one step per clock when high.
- dir  input  1  0 = up, 1 = down.
- mode  input  1  0 = one-hot ring, 1 = Johnson (twisted ring).
- load  input  1  synchronous load of load_pos.
- load_pos  input  PW  step index to load.
- out  output  WIDTH  registered ring code.
- pos  output  PW  registered binary step index matching out.
- wrap  output  1  registered one-cycle pulse on sequence wrap.

Behaviour:
- Reset (reset=0, async, any time): out = 1<<RESET_POS, pos = RESET_POS, internal mode_q = 0, wrap = 0. Reset mid-sequence aborts immediately; the first step after release starts from RESET_POS.
- All state changes occur on the rising edge of clock. Outputs are registered; out and pos are always mutually consistent in the same cycle.
- One-hot mode (mode_q=0): step k has out = 1<<k, k in 0..WIDTH-1.
  - Up: bit i moves to i+1; bit WIDTH-1 moves to bit 0.
  - Down: the reverse rotation.
- Johnson mode (mode_q=1): 2*WIDTH steps.
  - Up: out <= {out[WIDTH-2:0], ~out[WIDTH-1]}.
  - Down: out <= {~out[0], out[WIDTH-1:1]}.
  - Step 0 = all zeros; step k (1..WIDTH) = low k bits set; step WIDTH+j = all ones with the low j bits cleared.
- Priority per edge: load > mode change > enable > hold.
  - Load: pos <= load_pos and out <= the code for that step in the current mode_q. If load_pos is out of range (>=WIDTH in one-hot, >=2*WIDTH in Johnson), load step 0 instead. wrap = 0.
  - Mode change (mode != mode_q, no load): mode_q <= mode, pos <= 0, out <= step-0 code of the new mode (one-hot 1, Johnson 0). wrap = 0. Enable is ignored that cycle.
  - Enable: advance one step in direction dir.
    - wrap = 1 in the same cycle that pos becomes 0 from the last step (up), or becomes the last step from 0 (down). Otherwise wrap = 0.
  - Hold: out and pos are unchanged; wrap = 0.
- Changing dir mid-sequence takes effect on the next enabled edge; there is no dead cycle.
- WIDTH=2: one-hot sequence 01,10; Johnson sequence 00,01,11,10.

Optional Feature:
- Macro: RING_ERR_DETECT_EN.
- Defined:
  - Adds output err (1 bit, registered, reset 0).
  - Each cycle, out is checked for legality in mode_q: exactly one bit set for one-hot; a valid Johnson code otherwise.
  - On an illegal code, the next edge sets err=1 for one cycle and forces out/pos to the reset state, with mode_q kept and wrap=0. This takes priority over load.
- Undefined: the err port and checker logic are absent. Illegal codes propagate through the shift rules unchanged.

Test Plan:
- Use WIDTH=8, RESET_POS=0 unless noted.
- Reset held 40 ns, then enable=1, dir=0, mode=0 -> out 01,02,04,...,80,01. wrap=1 only with the cycle out=01 after 80; pos tracks 0..7.
- dir=1 from reset -> out 01,80,40,... ; wrap=1 with out=80, pos=7.
- mode=1, enable=1, dir=0 -> one edge to out=00, pos=0, then 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00. wrap=1 at the 00 step; pos reaches 15.
- load=1, load_pos=5 together with enable in one-hot mode -> out=20, pos=5. Next enabled edge gives out=40. load_pos=9 -> out=01, pos=0.
- Assert reset mid-count at out=10 asynchronously (between edges) -> out=01, pos=0, wrap=0 immediately. Build with RESET_POS=3 -> out=08 after reset.
- With RING_ERR_DETECT_EN: force out=03 for one cycle, then release -> err=1 for exactly one cycle, then out=01, pos=0 and counting resumes.

Source files
------------

// File: rtl/param_ring_counter.sv
// param_ring_counter: WIDTH-bit ring sequencer (one-hot or Johnson)
// with run-time direction, synchronous load, position readout and wrap.
//
// Parameters:
//   WIDTH      number of output bits, 2..32
//   RESET_POS  one-hot bit index restored by reset, < WIDTH
//   PW         width of pos/load_pos, derived as $clog2(2*WIDTH)
//
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-low reset
//   enable    advance one step per clock when high
//   dir       0 = up, 1 = down
//   mode      0 = one-hot ring, 1 = Johnson (twisted ring)
//   load      synchronous load of load_pos (highest priority)
//   load_pos  step index to load
//   out       registered ring code
//   pos       registered binary step index matching out
//   wrap      registered one-cycle pulse on sequence wrap
//   err       (RING_ERR_DETECT_EN only) one-cycle pulse when an illegal
//             code was seen and the counter was forced back to reset
//
// Optional feature macro: RING_ERR_DETECT_EN adds the code checker and err.

module param_ring_counter #(
    parameter int WIDTH     = 8,
    parameter int RESET_POS = 0,
    localparam int PW       = $clog2(2 * WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [PW-1:0]    load_pos,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    pos,
    output logic             wrap
`ifdef RING_ERR_DETECT_EN
    ,
    output logic             err
`endif
);

    localparam logic [WIDTH-1:0] W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ONES  = {WIDTH{1'b1}};
    localparam logic [PW-1:0]    P_ONE   = PW'(1);
    localparam logic [PW-1:0]    P_ZERO  = '0;
    localparam logic [PW-1:0]    P_WIDTH = PW'(WIDTH);
    localparam logic [PW-1:0]    OH_LAST = PW'(WIDTH - 1);
    localparam logic [PW-1:0]    JC_LAST = PW'(2 * WIDTH - 1);
    localparam logic [PW-1:0]    RST_POS = PW'(RESET_POS);
    localparam logic [WIDTH-1:0] RST_OUT = W_ONE << RESET_POS;

    logic             mode_q;
    logic             mode_n;
    logic [WIDTH-1:0] out_n;
    logic [PW-1:0]    pos_n;
    logic             wrap_n;
    logic [PW-1:0]    last;
    logic [PW-1:0]    load_step;
    logic             chk_fail;

    // Code for step k. Johnson: steps 0..WIDTH fill ones from the
    // bottom, steps WIDTH+j clear the low j bits again.
    function automatic logic [WIDTH-1:0] step_code(
        input logic          jc,
        input logic [PW-1:0] k
    );
        logic [WIDTH-1:0] code;
        if (!jc) begin
            code = W_ONE << k;
        end else if (k <= P_WIDTH) begin
            code = ~(W_ONES << k);
        end else begin
            code = W_ONES << (k - P_WIDTH);
        end
        return code;
    endfunction

`ifdef RING_ERR_DETECT_EN
    // Exactly one bit set.
    function automatic logic onehot_ok(input logic [WIDTH-1:0] c);
        return (c != '0) && ((c & (c - W_ONE)) == '0);
    endfunction

    // Legal Johnson codes are a block of ones anchored at bit 0, or a
    // block of ones anchored at the top bit (its complement is the former).
    function automatic logic johnson_ok(input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] nc;
        nc = ~c;
        return ((c & (c + W_ONE)) == '0) || ((nc & (nc + W_ONE)) == '0);
    endfunction

    assign chk_fail = mode_q ? !johnson_ok(out) : !onehot_ok(out);
`else
    assign chk_fail = 1'b0;
`endif

    assign last      = mode_q ? JC_LAST : OH_LAST;
    assign load_step = (load_pos > last) ? P_ZERO : load_pos;

    always_comb begin
        out_n  = out;
        pos_n  = pos;
        mode_n = mode_q;
        wrap_n = 1'b0;
        if (chk_fail) begin
            out_n = RST_OUT;
            pos_n = RST_POS;
        end else if (load) begin
            pos_n = load_step;
            out_n = step_code(mode_q, load_step);
        end else if (mode != mode_q) begin
            // Mode switch restarts at step 0; enable is ignored here.
            mode_n = mode;
            pos_n  = P_ZERO;
            out_n  = mode ? '0 : W_ONE;
        end else if (enable) begin
            if (!dir) begin
                out_n[WIDTH-1:1] = out[WIDTH-2:0];
                out_n[0]         = mode_q ? ~out[WIDTH-1] : out[WIDTH-1];
                wrap_n           = (pos == last);
                pos_n            = (pos == last) ? P_ZERO : pos + P_ONE;
            end else begin
                out_n[WIDTH-2:0] = out[WIDTH-1:1];
                out_n[WIDTH-1]   = mode_q ? ~out[0] : out[0];
                wrap_n           = (pos == P_ZERO);
                pos_n            = (pos == P_ZERO) ? last : pos - P_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out    <= RST_OUT;
            pos    <= RST_POS;
            mode_q <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            out    <= out_n;
            pos    <= pos_n;
            mode_q <= mode_n;
            wrap   <= wrap_n;
        end
    end

`ifdef RING_ERR_DETECT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else begin
            err <= chk_fail;
        end
    end
`endif

endmodule

// File: tb/tb_param_ring_counter.sv
// tb_param_ring_counter: scoreboard bench for param_ring_counter.
// A step-index model predicts out/pos/wrap for every driven edge.

module tb_param_ring_counter;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic          enable   = 1'b0;
    logic          dir      = 1'b0;
    logic          mode     = 1'b0;
    logic          load     = 1'b0;
    logic [PW-1:0] load_pos = '0;
    logic [W-1:0]  out, out2;
    logic [PW-1:0] pos, pos2;
    logic          wrap, wrap2;
`ifdef RING_ERR_DETECT_EN
    logic          err, err2;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]  out;
        logic [PW-1:0] pos;
        logic          wrap;
    } exp_t;

    exp_t q[$];
    logic m_mode = 1'b0;
    int   m_pos  = 0;

    always #5 clock = ~clock;

    param_ring_counter #(.WIDTH(W), .RESET_POS(0)) dut (
        .clock(clock), .reset(reset), .enable(enable), .dir(dir),
        .mode(mode), .load(load), .load_pos(load_pos),
        .out(out), .pos(pos), .wrap(wrap)
`ifdef RING_ERR_DETECT_EN
        , .err(err)
`endif
    );

    param_ring_counter #(.WIDTH(W), .RESET_POS(3)) dut2 (
        .clock(clock), .reset(reset), .enable(enable), .dir(dir),
        .mode(mode), .load(load), .load_pos(load_pos),
        .out(out2), .pos(pos2), .wrap(wrap2)
`ifdef RING_ERR_DETECT_EN
        , .err(err2)
`endif
    );

    function automatic logic [W-1:0] code(input logic jc, input int k);
        logic [W-1:0] c;
        for (int i = 0; i < W; i++) begin
            if (!jc)        c[i] = (i == k);
            else if (k <= W) c[i] = (i < k);
            else            c[i] = (i >= k - W);
        end
        return c;
    endfunction

    task automatic drive(input logic en, input logic d, input logic m,
                         input logic ld, input int lp);
        exp_t e;
        int n;
        enable   = en;
        dir      = d;
        mode     = m;
        load     = ld;
        load_pos = lp[PW-1:0];
        e.wrap   = 1'b0;
        n = m_mode ? 2 * W : W;
        if (ld) begin
            m_pos = (lp >= n) ? 0 : lp;
        end else if (m != m_mode) begin
            m_mode = m;
            m_pos  = 0;
        end else if (en) begin
            if (!d) begin
                e.wrap = (m_pos == n - 1);
                m_pos  = (m_pos + 1) % n;
            end else begin
                e.wrap = (m_pos == 0);
                m_pos  = (m_pos + n - 1) % n;
            end
        end
        e.out = code(m_mode, m_pos);
        e.pos = m_pos[PW-1:0];
        q.push_back(e);
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        mode   = 1'b0;
        dir    = 1'b0;
        #40;
        @(negedge clock);
        reset  = 1'b1;
        m_mode = 1'b0;
        m_pos  = 0;
        q.delete();
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        enable = 1'b1;
        #40;
        checks++;
        if ({out, pos, wrap} !== {8'h01, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_pos0: out=%h pos=%0d wrap=%b want 01/0/0",
                     out, pos, wrap);
        end
        checks++;
        if ({out2, pos2, wrap2} !== {8'h08, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL reset_pos3: out=%h pos=%0d wrap=%b want 08/3/0",
                     out2, pos2, wrap2);
        end
        @(negedge clock);
        enable = 1'b0;
        reset  = 1'b1;
        m_mode = 1'b0;
        m_pos  = 0;
        q.delete();
        @(posedge clock);
        #1;
        checks++;
        if ({out, pos, wrap} !== {8'h01, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: out=%h pos=%0d wrap=%b want 01/0/0",
                     out, pos, wrap);
        end
    endtask

    task automatic test_onehot_up;
        exp_t e;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
            @(posedge clock);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, pos, wrap} !== {e.out, e.pos, e.wrap}) begin
                errors++;
                $display("FAIL onehot_up[%0d]: out=%h pos=%0d wrap=%b want %h/%0d/%b",
                         i, out, pos, wrap, e.out, e.pos, e.wrap);
            end
        end
    endtask

    task automatic test_onehot_down;
        exp_t e;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
            @(posedge clock);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, pos, wrap} !== {e.out, e.pos, e.wrap}) begin
                errors++;
                $display("FAIL onehot_down[%0d]: out=%h pos=%0d wrap=%b want %h/%0d/%b",
                         i, out, pos, wrap, e.out, e.pos, e.wrap);
            end
        end
    endtask

    task automatic test_johnson;
        exp_t e;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            // first edge is the mode switch; last four reverse direction
            drive(1'b1, (i >= 17), 1'b1, 1'b0, 0);
            @(posedge clock);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, pos, wrap} !== {e.out, e.pos, e.wrap}) begin
                errors++;
                $display("FAIL johnson[%0d]: out=%h pos=%0d wrap=%b want %h/%0d/%b",
                         i, out, pos, wrap, e.out, e.pos, e.wrap);
            end
        end
    endtask

    task automatic test_load;
        exp_t e;
        logic [4:0] en_v [8] = '{1, 1, 0, 1, 0, 1, 0, 0};
        logic       md_v [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
        logic       ld_v [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
        int         lp_v [8] = '{5, 0, 0, 9, 0, 9, 3, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(en_v[i][0], 1'b0, md_v[i], ld_v[i], lp_v[i]);
            @(posedge clock);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, pos, wrap} !== {e.out, e.pos, e.wrap}) begin
                errors++;
                $display("FAIL load[%0d]: out=%h pos=%0d wrap=%b want %h/%0d/%b",
                         i, out, pos, wrap, e.out, e.pos, e.wrap);
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
            @(posedge clock);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, pos, wrap} !== {e.out, e.pos, e.wrap}) begin
                errors++;
                $display("FAIL async_pre[%0d]: out=%h pos=%0d wrap=%b want %h/%0d/%b",
                         i, out, pos, wrap, e.out, e.pos, e.wrap);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({out, pos, wrap} !== {8'h01, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: out=%h pos=%0d wrap=%b want 01/0/0",
                     out, pos, wrap);
        end
        @(negedge clock);
        reset  = 1'b1;
        m_mode = 1'b0;
        m_pos  = 0;
        q.delete();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clock);
        #1;
        e = q.pop_front();
        checks++;
        if ({out, pos, wrap} !== {e.out, e.pos, e.wrap}) begin
            errors++;
            $display("FAIL async_resume: out=%h pos=%0d wrap=%b want %h/%0d/%b",
                     out, pos, wrap, e.out, e.pos, e.wrap);
        end
    endtask

    task automatic test_random;
        exp_t e;
        logic m;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            m = ($urandom % 8 == 0) ? ~m_mode : m_mode;
            drive(($urandom % 4) != 0, $urandom % 2, m,
                  ($urandom % 10) == 0, $urandom % 16);
            @(posedge clock);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, pos, wrap} !== {e.out, e.pos, e.wrap}) begin
                errors++;
                $display("FAIL random[%0d]: out=%h pos=%0d wrap=%b want %h/%0d/%b",
                         i, out, pos, wrap, e.out, e.pos, e.wrap);
            end
        end
    endtask

`ifdef RING_ERR_DETECT_EN
    task automatic test_err;
        do_reset();
        enable = 1'b1;
        @(posedge clock);
        #1;
        force dut.out = 8'h03;
        @(negedge clock);
        release dut.out;
        @(posedge clock);
        #1;
        checks++;
        if ({err, out, pos, wrap} !== {1'b1, 8'h01, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL err_hit: err=%b out=%h pos=%0d wrap=%b want 1/01/0/0",
                     err, out, pos, wrap);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({err, out, pos} !== {1'b0, 8'h02, 4'd1}) begin
            errors++;
            $display("FAIL err_clear: err=%b out=%h pos=%0d want 0/02/1",
                     err, out, pos);
        end
        enable = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_onehot_up();
        test_onehot_down();
        test_johnson();
        test_load();
        test_async_reset();
`ifdef RING_ERR_DETECT_EN
        test_err();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
